// File: rtl/ib_ram_wr_fsm_pkg.sv
// Shared definitions for the IB-RAM iteration-update writer.
// The state codes double as the {iter_update, wr_busy} status word that
// sys_control_unit decodes, so the encoding is fixed and must not be re-assigned.
package ib_ram_wr_fsm_pkg;

    localparam int IB_WR_STATUS_W = 3;

    typedef enum logic [IB_WR_STATUS_W-1:0] {
        IB_WR_IDLE   = 3'b000,
        IB_WR_FETCH  = 3'b101,
        IB_WR_FINISH = 3'b010
    } ib_wr_state_e;

    // Two LUT entries are packed per ROM word, so one update takes half as many reads.
    function automatic int load_cycles(input int entry_num);
        return entry_num / 2;
    endfunction

endpackage

// File: rtl/ib_ram_wr_fsm.sv
// IB-RAM iteration-update writer: on a controller request, copies the current
// iteration page from IB-ROM into the two interleaved IB-RAM banks, then
// advances the page index (wrapping after MAX_ITER pages).
//
// Handshake with the controller is a 4-phase level protocol:
//   wr_req rises -> FETCH (status 101) until the whole page is written ->
//   FINISH (status 010) held while wr_req stays high -> IDLE once wr_req drops.
// wr_req falling during FETCH does not abort the page.
// upd_en only gates new ROM reads; a read already issued always gets written.
module ib_ram_wr_fsm
    import ib_ram_wr_fsm_pkg::*;
#(
    parameter  int ENTRY_NUM  = 64,
    parameter  int DATA_W     = 4,
    parameter  int MAX_ITER   = 50,
    localparam int LOAD_CYCLE = load_cycles(ENTRY_NUM),
    localparam int PAGE_W     = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1,
    localparam int WORD_W     = (LOAD_CYCLE > 1) ? $clog2(LOAD_CYCLE) : 1
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     wr_req,
    input  logic                     upd_en,
    output logic                     iter_update,
    output logic [1:0]               wr_busy,
    output logic [PAGE_W+WORD_W-1:0] rom_addr,
    output logic                     rom_rd,
    input  logic [2*DATA_W-1:0]      rom_data,
    output logic [WORD_W-1:0]        ram_addr,
    output logic [1:0]               ram_we,
    output logic [DATA_W-1:0]        ram_din0,
    output logic [DATA_W-1:0]        ram_din1,
    output logic [PAGE_W-1:0]        page_idx
);

    ib_wr_state_e      state;
    ib_wr_state_e      state_nxt;

    // One extra bit so the counter can sit at LOAD_CYCLE once every word is issued.
    logic [WORD_W:0]   word_idx;
    logic [PAGE_W-1:0] page_q;
    logic              rd_go;
    logic              last_wr;

    assign rd_go   = (state == IB_WR_FETCH) && upd_en &&
                     (word_idx < (WORD_W+1)'(LOAD_CYCLE));
    assign last_wr = (state == IB_WR_FETCH) && ram_we[0] &&
                     (ram_addr == WORD_W'(LOAD_CYCLE - 1));

    // Status is the state register itself, so it never glitches.
    assign {iter_update, wr_busy} = state;

    assign rom_rd   = rd_go;
    assign rom_addr = {page_q, word_idx[WORD_W-1:0]};
    assign page_idx = page_q;

    // ROM data arrives in the same cycle as the registered write enable; gate it so
    // the banks see zero data whenever no write is happening.
    assign ram_din0 = ram_we[0] ? rom_data[DATA_W-1:0]        : '0;
    assign ram_din1 = ram_we[1] ? rom_data[2*DATA_W-1:DATA_W] : '0;

    // State register.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IB_WR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; unknown codes fall back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IB_WR_IDLE:   if (wr_req)   state_nxt = IB_WR_FETCH;
            IB_WR_FETCH:  if (last_wr)  state_nxt = IB_WR_FINISH;
            IB_WR_FINISH: if (!wr_req)  state_nxt = IB_WR_IDLE;
            default:                    state_nxt = IB_WR_IDLE;
        endcase
    end

    // ROM word counter: restarts on each new request, advances on every issued read.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            word_idx <= '0;
        end else if ((state == IB_WR_IDLE) && wr_req) begin
            word_idx <= '0;
        end else if (rd_go) begin
            word_idx <= word_idx + (WORD_W+1)'(1);
        end
    end

    // Page index advances once the final word of the page lands in RAM.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            page_q <= '0;
        end else if (last_wr) begin
            page_q <= (page_q == PAGE_W'(MAX_ITER - 1)) ? '0 : page_q + PAGE_W'(1);
        end
    end

    // Write stage: one cycle behind the ROM read, both banks written together.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            ram_we   <= 2'b00;
            ram_addr <= '0;
        end else begin
            ram_we <= {2{rd_go}};
            if (rd_go) begin
                ram_addr <= word_idx[WORD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ib_ram_wr_fsm.sv
// Directed bench for ib_ram_wr_fsm: ROM model, write scoreboard, page-index model.
module tb_ib_ram_wr_fsm;

  localparam int ENTRY_NUM  = 64;
  localparam int DATA_W     = 4;
  localparam int MAX_ITER   = 50;
  localparam int LOAD_CYCLE = ENTRY_NUM / 2;
  localparam int PAGE_W     = $clog2(MAX_ITER);
  localparam int WORD_W     = $clog2(LOAD_CYCLE);
  localparam int SB_W       = WORD_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rstn;
  always #5 sys_clk = ~sys_clk;

  logic                     wr_req;
  logic                     upd_en;
  logic                     iter_update;
  logic [1:0]               wr_busy;
  logic [PAGE_W+WORD_W-1:0] rom_addr;
  logic                     rom_rd;
  logic [2*DATA_W-1:0]      rom_data = '0;
  logic [WORD_W-1:0]        ram_addr;
  logic [1:0]               ram_we;
  logic [DATA_W-1:0]        ram_din0;
  logic [DATA_W-1:0]        ram_din1;
  logic [PAGE_W-1:0]        page_idx;
  logic [2:0]               status;

  assign status = {iter_update, wr_busy};

  ib_ram_wr_fsm #(
    .ENTRY_NUM (ENTRY_NUM),
    .DATA_W    (DATA_W),
    .MAX_ITER  (MAX_ITER)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .wr_req      (wr_req),
    .upd_en      (upd_en),
    .iter_update (iter_update),
    .wr_busy     (wr_busy),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_din0    (ram_din0),
    .ram_din1    (ram_din1),
    .page_idx    (page_idx)
  );

  int tests_run = 0;
  int fail_cnt  = 0;
  int exp_page  = 0;
  logic [SB_W-1:0] exp_q[$];

  // ROM contents: page 0 holds the word index itself, later pages are offset.
  function automatic logic [2*DATA_W-1:0] rom_word(input int page, input int word);
    return (2*DATA_W)'(word + page * 37);
  endfunction

  // Synchronous ROM: data valid the cycle after rom_rd.
  always @(posedge sys_clk) begin
    if (rom_rd)
      rom_data <= rom_word(int'(rom_addr[PAGE_W+WORD_W-1:WORD_W]), int'(rom_addr[WORD_W-1:0]));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge sys_clk) begin
    if (ram_we != 2'b00) begin
      logic [SB_W-1:0] exp_e;
      check("wr_enable_both", 32'(ram_we), 32'(2'b11));
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr_data", 32'({ram_addr, ram_din1, ram_din0}), 32'(exp_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One full update. pause_at/drop_at < 0 disables that feature.
  task automatic run_page(input int pause_at, input int pause_len,
                          input int drop_at, input int finish_hold);
    int fetch_cycles;
    int rd_cnt;
    logic paused;
    check("page_idx_before", 32'(page_idx), 32'(exp_page));
    for (int w = 0; w < LOAD_CYCLE; w++)
      exp_q.push_back({WORD_W'(w), rom_word(exp_page, w)});
    wr_req = 1'b1;
    upd_en = 1'b1;
    @(negedge sys_clk);
    check("fetch_entry", 32'(status), 32'(3'b101));
    fetch_cycles = 0;
    rd_cnt = 0;
    while (status == 3'b101 && fetch_cycles < 200) begin
      paused = (pause_at >= 0) && (fetch_cycles >= pause_at) &&
               (fetch_cycles < pause_at + pause_len);
      upd_en = !paused;
      if (fetch_cycles == drop_at) wr_req = 1'b0;
      #1;
      if (paused) check("rom_rd_paused", 32'(rom_rd), 32'd0);
      if (paused && fetch_cycles == pause_at)
        check("inflight_write_in_pause", 32'(ram_we), 32'(2'b11));
      if (rom_rd) begin
        check("rom_page", 32'(rom_addr[PAGE_W+WORD_W-1:WORD_W]), 32'(exp_page));
        check("rom_word", 32'(rom_addr[WORD_W-1:0]), 32'(rd_cnt));
        rd_cnt++;
      end
      fetch_cycles++;
      @(negedge sys_clk);
    end
    upd_en = 1'b1;
    check("fetch_cycles", 32'(fetch_cycles), 32'(LOAD_CYCLE + 1 + (pause_at >= 0 ? pause_len : 0)));
    check("rom_reads", 32'(rd_cnt), 32'(LOAD_CYCLE));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_page = (exp_page == MAX_ITER - 1) ? 0 : exp_page + 1;
    check("finish_status", 32'(status), 32'(3'b010));
    check("finish_no_write", 32'(ram_we), 32'd0);
    check("page_idx_after", 32'(page_idx), 32'(exp_page));
    if (drop_at >= 0) begin
      @(negedge sys_clk);
      check("idle_after_drop", 32'(status), 32'(3'b000));
    end else begin
      for (int i = 1; i < finish_hold; i++) begin
        @(negedge sys_clk);
        check("finish_hold", 32'(status), 32'(3'b010));
      end
      wr_req = 1'b0;
      @(negedge sys_clk);
      check("idle_after_release", 32'(status), 32'(3'b000));
    end
  endtask

  // Start an update, then pulse rstn mid-cycle once word at_word is being read.
  task automatic reset_mid_fetch(input int at_word);
    int guard;
    for (int w = 0; w < LOAD_CYCLE; w++)
      exp_q.push_back({WORD_W'(w), rom_word(exp_page, w)});
    wr_req = 1'b1;
    upd_en = 1'b1;
    guard = 0;
    do begin
      @(negedge sys_clk);
      #1;
      guard++;
    end while (!(rom_rd && rom_addr[WORD_W-1:0] == WORD_W'(at_word)) && guard < 100);
    check("reached_reset_word", 32'(guard < 100), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_status", 32'(status), 32'(3'b000));
    check("async_rst_ram_we", 32'(ram_we), 32'd0);
    check("async_rst_page", 32'(page_idx), 32'd0);
    check("async_rst_rom_rd", 32'(rom_rd), 32'd0);
    wr_req = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b1;
    exp_q.delete();
    exp_page = 0;
    @(negedge sys_clk);
    check("idle_after_reset", 32'(status), 32'(3'b000));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn   = 1'b0;
    wr_req = 1'b0;
    upd_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_status",   32'(status),   32'(3'b000));
    check("rst_rom_rd",   32'(rom_rd),   32'd0);
    check("rst_ram_we",   32'(ram_we),   32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_din",      32'({ram_din1, ram_din0}), 32'd0);
    check("rst_page",     32'(page_idx), 32'd0);
    rstn = 1'b1;
    @(negedge sys_clk);

    run_page(-1, 0, -1, 1);     // plain update, page 0
    run_page(5, 5, -1, 1);      // upd_en low for fetch cycles 5..9
    run_page(-1, 0, -1, 10);    // FINISH held 10 cycles
    run_page(-1, 0, 3, 1);      // wr_req dropped early in FETCH
    reset_mid_fetch(17);
    run_page(-1, 0, -1, 1);     // restart from word 0, page 0
    for (int i = 0; i < MAX_ITER; i++)
      run_page(-1, 0, -1, 1);   // last one wraps back to page 0
    check("final_page", 32'(page_idx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
